// File: rtl/pause_fade_ctrl.sv
// Pause controller for arcade cores: merges pause sources, optional vblank-aligned entry,
// single-frame step while paused, and a stepped RGB fade-down during long pauses.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_RUN     | CPU running, no pause wanted
// ST_PENDING | pause wanted, CPU still running until the next vblank rise
// ST_PAUSED  | CPU halted; fade timers run when dimming is enabled
// ST_STEP    | frame advance: CPU runs until the next vblank rise
module pause_fade_ctrl #(
    parameter int          RW          = 4,
    parameter int          GW          = 4,
    parameter int          BW          = 4,
    parameter int          CLKSPD      = 3,
    parameter int          NREQ        = 2,
    parameter int unsigned DIM_CYCLES  = CLKSPD * 10000000,
    parameter int unsigned FADE_CYCLES = CLKSPD * 500000,
    parameter int          DIM_MAX     = 2
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic                  user_button,
    input  logic                  step_button,
    input  logic [NREQ-1:0]       pause_request,
    input  logic [2:0]            options,
    input  logic                  OSD_STATUS,
    input  logic                  vblank,
    input  logic [RW-1:0]         r,
    input  logic [GW-1:0]         g,
    input  logic [BW-1:0]         b,
    output logic                  pause_cpu,
    output logic [1:0]            dim_level,
    output logic [RW+GW+BW-1:0]   rgb_out
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PENDING = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_STEP    = 2'd3
    } state_t;

    localparam logic [31:0] HOLD_TC = DIM_CYCLES;
    localparam logic [31:0] FADE_TC = FADE_CYCLES - 1;
    localparam logic [1:0]  DIM_SAT = DIM_MAX[1:0];

    state_t              state_q, state_d;
    logic                toggle_q, toggle_d;
    logic                user_last_q, step_last_q, vblank_last_q;
    logic                pause_q;
    logic [31:0]         hold_q, hold_d;
    logic [31:0]         fade_q, fade_d;
    logic [1:0]          dim_q, dim_d;
    logic [RW+GW+BW-1:0] rgb_q;

    logic want, rise_user, rise_step, rise_vblank;

    assign rise_user   = user_button & ~user_last_q;
    assign rise_step   = step_button & ~step_last_q;
    assign rise_vblank = vblank & ~vblank_last_q;
    assign want        = (|pause_request) | toggle_q | (OSD_STATUS & options[0]);

    always_comb begin
        state_d  = state_q;
        toggle_d = toggle_q ^ rise_user;
        case (state_q)
            ST_RUN:     if (want) state_d = options[2] ? ST_PENDING : ST_PAUSED;
            ST_PENDING: if (!want) state_d = ST_RUN;
                        else if (rise_vblank) state_d = ST_PAUSED;
            ST_PAUSED:  if (!want) state_d = ST_RUN;
                        else if (rise_step) state_d = ST_STEP;
            ST_STEP:    if (!want) state_d = ST_RUN;
                        else if (rise_vblank) state_d = ST_PAUSED;
            default:    state_d = ST_RUN;
        endcase
    end

    // Fade timers follow the next state so the dim clears together with the unpause.
    always_comb begin
        hold_d = '0;
        fade_d = '0;
        dim_d  = '0;
        if (state_d == ST_PAUSED && options[1]) begin
            hold_d = hold_q;
            fade_d = fade_q;
            dim_d  = dim_q;
            if (hold_q != HOLD_TC) begin
                hold_d = hold_q + 32'd1;
                if (hold_q + 32'd1 == HOLD_TC) dim_d = 2'd1;
            end else if (dim_q < DIM_SAT) begin
                if (fade_q == FADE_TC) begin
                    fade_d = '0;
                    dim_d  = dim_q + 2'd1;
                end else begin
                    fade_d = fade_q + 32'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q       <= ST_RUN;
            toggle_q      <= 1'b0;
            user_last_q   <= 1'b0;
            step_last_q   <= 1'b0;
            vblank_last_q <= 1'b0;
            pause_q       <= 1'b0;
            hold_q        <= '0;
            fade_q        <= '0;
            dim_q         <= '0;
            rgb_q         <= '0;
        end else begin
            state_q       <= state_d;
            toggle_q      <= toggle_d;
            user_last_q   <= user_button;
            step_last_q   <= step_button;
            vblank_last_q <= vblank;
            pause_q       <= (state_d == ST_PAUSED);
            hold_q        <= hold_d;
            fade_q        <= fade_d;
            dim_q         <= dim_d;
            rgb_q         <= {r >> dim_q, g >> dim_q, b >> dim_q};
        end
    end

    assign pause_cpu = pause_q;
    assign dim_level = dim_q;
    assign rgb_out   = rgb_q;

endmodule

// File: doc/pause_fade_ctrl.md
Name: pause_fade_ctrl

Overview:
- Second-generation pause controller for arcade cores.
- Merges N pause-request sources, user toggle and OSD pause, and optionally aligns pause entry to vblank.
- Adds a single-frame step mode while paused.
- Replaces the one-shot video dim with a stepped fade to burn-in levels. Sits between the core's video/CPU and the arcade_video module.

Parameters:
- RW, 4, red channel width
- GW, 4, green channel width
- BW, 4, blue channel width
- CLKSPD, 3, clk_sys in MHz
- NREQ, 2, number of pause_request sources
- DIM_CYCLES, CLKSPD*10000000, paused cycles before the first dim step
- FADE_CYCLES, CLKSPD*500000, cycles between successive dim steps
- DIM_MAX, 2, maximum shift applied to RGB (1..3)

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high
- user_button  in  1  pause toggle button, active-high
- step_button  in  1  frame-advance button, active-high
- pause_request  in  NREQ  pause requests from other logic, any bit pauses
- options  in  3  [0] pause in OSD, [1] dim enable, [2] sync pause entry to vblank
- OSD_STATUS  in  1  OSD open
- vblank  in  1  core vblank, clk_sys domain
- r  in  RW  red
- g  in  GW  green
- b  in  BW  blue
- pause_cpu  out  1  CPU halt, registered
- dim_level  out  2  current RGB shift, 0..DIM_MAX
- rgb_out  out  RW+GW+BW  {r,g,b} after dim, registered

Behaviour:
- Reset: state RUN, pause_cpu=0, user toggle=0, dim_level=0, timers=0, rgb_out=0, edge registers (user/step/vblank last)=0. Reset overrides every simultaneous event.
- Edges: rise_x = x & ~x_last, with x_last registered every cycle.
- user_button rise flips the toggle. Reset clears it.
- want = |pause_request | toggle | (OSD_STATUS & options[0]).
- States (2-bit reg): RUN, PENDING, PAUSED, STEP. pause_cpu=1 exactly when the state register is PAUSED (registered, one cycle after the deciding edge).
- RUN: want & options[2] -> PENDING; want & ~options[2] -> PAUSED.
- PENDING: ~want -> RUN; else vblank rise -> PAUSED. CPU keeps running.
- PAUSED: ~want -> RUN; else step rise -> STEP.
- STEP: ~want -> RUN; else vblank rise -> PAUSED. This runs exactly one vblank-to-vblank frame. A step rise in STEP is ignored.
- If ~want and vblank rise occur in the same cycle, the transition goes to RUN.
- If the step rise occurs outside PAUSED, it is ignored.
- If options[2] is cleared while PENDING, stay in PENDING until vblank or ~want.
- Dim: counters run only in PAUSED with options[1]=1.
  - The 32-bit hold counter counts to DIM_CYCLES.
  - On reaching DIM_CYCLES, dim_level goes to 1. After that, dim_level increments every FADE_CYCLES (separate counter) until it saturates at DIM_MAX. Counters stop at saturation.
  - In any other state, or with options[1]=0, both counters and dim_level clear next cycle.
- Video: rgb_out <= {r>>dim_level, g>>dim_level, b>>dim_level}, shifting each channel independently at its own width. Latency is 1 clk_sys. rgb_out always updates, including while paused.

Test Plan (DIM_CYCLES=100, FADE_CYCLES=10, DIM_MAX=2, NREQ=2, options=3'b010 unless noted):
- user_button pulse -> pause_cpu=1 from 2nd cycle after the rise. Second pulse -> pause_cpu=0. Reset while paused -> pause_cpu=0 and toggle cleared. A later button press pauses again.
- options[2]=1, pause_request=2'b10 mid-frame -> pause_cpu stays 0 until the cycle after the vblank rise, then 1. Dropping the request before vblank -> pause_cpu never asserts.
- Paused, step_button pulse -> pause_cpu=0 until the vblank rise, then 1. A second step pulse during STEP has no effect.
- Paused with r=g=b=4'hF -> rgb_out=12'hFFF for 100 cycles. Then 12'h777 (dim_level=1). 10 cycles later 12'h333 (dim_level=2), which holds. Unpause -> dim_level=0 and rgb_out=12'hFFF the next cycle.
- options[0]=1, OSD_STATUS=1 -> paused. options[0]=0 -> unpaused next cycle. OSD_STATUS with options[0]=0 -> no pause.
- user_button rise together with reset -> toggle=0, pause_cpu=0. Step in RUN -> no state change.
